spi_shift_mlane: RTL and testbench

- Parametrised SPI character shift engine for single, dual and quad lanes.
- Replaces the fixed 32-bit single-lane shifter inside the SPI host.
- Sits between the register interface (word/byte-lane loads, parallel read-out) and the clock generator, which supplies sclk_i and the pos_edge_i/neg_edge_i strobes.
- Adds: separate tx/rx registers, lane modes, output enables, synchronous abort, a done pulse, and full async reset of all state.

---
 rtl/spi_shift_mlane.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_spi_shift_mlane.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_mlane.sv
// spi_shift_mlane
// Character shift engine for an SPI host with single, dual and quad lanes.
// Holds separate transmit and receive character registers. Transfers are
// paced by sclk edge strobes from the clock generator and counted in beats,
// where each beat moves k bits (k = 1, 2 or 4 lanes).

module spi_shift_mlane #(
    parameter int MAX_CHAR = 128,
    parameter int BUS_W    = 32,
    parameter int LEN_W    = $clog2(MAX_CHAR),
    parameter int WSEL_W   = ((MAX_CHAR / BUS_W) > 1) ? $clog2(MAX_CHAR / BUS_W) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic [WSEL_W-1:0]     word_sel_i,
    input  logic [BUS_W/8-1:0]    byte_sel_i,
    input  logic [BUS_W-1:0]      wdata_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic                  lsb_i,
    input  logic [1:0]            lanes_i,
    input  logic                  tx_negedge_i,
    input  logic                  rx_negedge_i,
    input  logic                  go_i,
    input  logic                  pos_edge_i,
    input  logic                  neg_edge_i,
    input  logic                  sclk_i,
    input  logic                  tx_en_i,
    input  logic                  rx_en_i,
    input  logic [3:0]            sd_i,
    output logic [3:0]            sd_o,
    output logic [3:0]            sd_oe_o,
    output logic                  busy_o,
    output logic                  last_o,
    output logic                  done_o,
    output logic [MAX_CHAR-1:0]   rdata_o
);

    localparam int NWORDS = MAX_CHAR / BUS_W;
    localparam int NBYTES = BUS_W / 8;
    localparam int CW     = LEN_W + 1;   // beat counter width
    localparam int PW     = LEN_W + 2;   // bit-position arithmetic width (room for wrap)

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Lowest register bit touched by a beat; lane i of that beat is base + i.
    // MSB first puts the highest bit of the beat on the top lane.
    function automatic logic [PW-1:0] beat_base(
        input logic [PW-1:0] idx,
        input logic [CW-1:0] n,
        input logic [1:0]    sh,
        input logic          lsb
    );
        logic [PW-1:0] step;
        step = idx << sh;
        if (lsb) begin
            return step;
        end else begin
            return PW'(n) - (PW'(1) << sh) - step;
        end
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [MAX_CHAR-1:0] r_tx;
    logic [MAX_CHAR-1:0] w_tx_nxt;
    logic [MAX_CHAR-1:0] r_rx;
    logic [MAX_CHAR-1:0] w_rx_nxt;
    logic [3:0]          r_sd;
    logic [3:0]          w_sd_nxt;
    logic [3:0]          r_oe;
    logic [3:0]          w_oe_nxt;
    logic                r_done;
    logic                w_done_nxt;

    logic [1:0]          w_shift;
    logic [2:0]          w_k;
    logic [3:0]          w_lane_en;
    logic [CW-1:0]       w_len_full;
    logic [CW-1:0]       w_n_rnd;
    logic [CW-1:0]       w_n;
    logic [CW-1:0]       w_b;
    logic                w_busy;
    logic                w_last;
    logic                w_start;
    logic                w_load;
    logic                w_txe;
    logic                w_rxe;
    logic [PW-1:0]       w_tx_idx;
    logic [PW-1:0]       w_tx_base;
    logic [3:0]          w_tx_beat;
    logic [PW-1:0]       w_rx_idx;
    logic [PW-1:0]       w_rx_base;
    logic                w_rx_valid;
    logic                w_rx_wr;
    logic [3:0]          w_rx_bits;

    // Lane mode decode: bits per beat and which lanes carry data.
    always_comb begin
        case (lanes_i)
            2'd1: begin
                w_shift   = 2'd1;
                w_k       = 3'd2;
                w_lane_en = 4'b0011;
            end
            2'd2: begin
                w_shift   = 2'd2;
                w_k       = 3'd4;
                w_lane_en = 4'b1111;
            end
            default: begin
                w_shift   = 2'd0;
                w_k       = 3'd1;
                w_lane_en = 4'b0001;
            end
        endcase
    end

    // Effective character length N (multiple of k, never zero) and beat count B.
    always_comb begin
        if (len_i == {LEN_W{1'b0}}) begin
            w_len_full = CW'(MAX_CHAR);
        end else begin
            w_len_full = {1'b0, len_i};
        end
        w_n_rnd = w_len_full & ~CW'(w_k - 3'd1);
        if (w_n_rnd == {CW{1'b0}}) begin
            w_n = CW'(w_k);
        end else begin
            w_n = w_n_rnd;
        end
        w_b = w_n >> w_shift;
    end

    assign w_busy  = (r_state == ST_BUSY);
    assign w_last  = (r_cnt == {CW{1'b0}});
    assign w_start = !w_busy && go_i && !clear_i;
    assign w_load  = load_i && !w_busy;
    assign w_txe   = (tx_negedge_i ? neg_edge_i : pos_edge_i) && !w_last;
    assign w_rxe   = (rx_negedge_i ? neg_edge_i : pos_edge_i) && (!w_last || sclk_i);

    // Transmit beat selection: beat 0 while idle (pre-drive), B - cnt while busy.
    always_comb begin
        w_tx_beat = 4'b0000;
        if (w_busy) begin
            w_tx_idx = PW'(w_b) - PW'(r_cnt);
        end else begin
            w_tx_idx = {PW{1'b0}};
        end
        w_tx_base = beat_base(w_tx_idx, w_n, w_shift, lsb_i);
        for (int i = 0; i < 4; i++) begin
            w_tx_beat[i] = w_lane_en[i] ? r_tx[LEN_W'(w_tx_base + PW'(i))] : 1'b0;
        end
    end

    // Receive beat selection and write qualification; half-duplex multi-lane
    // modes give the lanes to the transmitter when tx_en_i is set.
    always_comb begin
        w_rx_idx   = PW'(w_b) - PW'(r_cnt) - (rx_negedge_i ? PW'(1) : PW'(0));
        w_rx_valid = (w_rx_idx < PW'(w_b));
        w_rx_base  = beat_base(w_rx_idx, w_n, w_shift, lsb_i);
        w_rx_wr    = w_busy && rx_en_i && !clear_i && w_rxe && w_rx_valid &&
                     !((w_shift != 2'd0) && tx_en_i);
        if (w_shift == 2'd0) begin
            w_rx_bits = {3'b000, sd_i[1]};
        end else begin
            w_rx_bits = sd_i;
        end
    end

    // Next receive register: deposit the sampled lanes at this beat's positions.
    always_comb begin
        w_rx_nxt = r_rx;
        for (int i = 0; i < 4; i++) begin
            w_rx_nxt[LEN_W'(w_rx_base + PW'(i))] =
                (w_rx_wr && w_lane_en[i]) ? w_rx_bits[i] : w_rx_nxt[LEN_W'(w_rx_base + PW'(i))];
        end
    end

    // Next transmit register: byte-lane writes into the selected word while idle.
    always_comb begin
        w_tx_nxt = r_tx;
        for (int w = 0; w < NWORDS; w++) begin
            for (int b = 0; b < NBYTES; b++) begin
                w_tx_nxt[w*BUS_W + b*8 +: 8] =
                    (w_load && (int'(word_sel_i) == w) && byte_sel_i[b]) ?
                    wdata_i[b*8 +: 8] : r_tx[w*BUS_W + b*8 +: 8];
            end
        end
    end

    // Beat counter: reloads with B when idle or aborted, counts down on pos_edge.
    always_comb begin
        if (clear_i || !w_busy) begin
            w_cnt_nxt = w_b;
        end else if (pos_edge_i && !w_last) begin
            w_cnt_nxt = r_cnt - CW'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Transfer FSM: abort wins over start and over the terminating edge.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (go_i && !clear_i) begin
                    w_state_nxt = ST_BUSY;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (clear_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last && pos_edge_i) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Serial output: pre-drive beat 0 while idle, advance on the tx strobe.
    always_comb begin
        if (!w_busy) begin
            w_sd_nxt = w_tx_beat;
        end else if (w_txe && !clear_i) begin
            w_sd_nxt = w_tx_beat;
        end else begin
            w_sd_nxt = r_sd;
        end
    end

    // Output enables follow the lane mode and tx_en_i.
    always_comb begin
        case (lanes_i)
            2'd1:    w_oe_nxt = {2'b00, {2{tx_en_i}}};
            2'd2:    w_oe_nxt = {4{tx_en_i}};
            default: w_oe_nxt = {3'b000, tx_en_i};
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CW{1'b0}};
            r_sd    <= 4'b0000;
            r_oe    <= 4'b0000;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sd    <= w_sd_nxt;
            r_oe    <= w_oe_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Character registers; the receive side is cleared when a transfer starts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx <= {MAX_CHAR{1'b0}};
            r_rx <= {MAX_CHAR{1'b0}};
        end else begin
            r_tx <= w_tx_nxt;
            if (w_start) begin
                r_rx <= {MAX_CHAR{1'b0}};
            end else begin
                r_rx <= w_rx_nxt;
            end
        end
    end

    assign sd_o    = r_sd;
    assign sd_oe_o = r_oe;
    assign busy_o  = w_busy;
    assign last_o  = w_last;
    assign done_o  = r_done;
    assign rdata_o = r_rx;

endmodule

// File: tb/tb_spi_shift_mlane.sv
// Directed bench for spi_shift_mlane: a simple sclk strobe generator,
// optional loopback of sd_o[0] into sd_i[1], and hand-computed expectations.

module tb_spi_shift_mlane;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         clear_i, load_i, lsb_i, tx_negedge_i, rx_negedge_i, go_i;
    logic         pos_edge_i, neg_edge_i, sclk_i, tx_en_i, rx_en_i;
    logic [1:0]   word_sel_i;
    logic [3:0]   byte_sel_i;
    logic [31:0]  wdata_i;
    logic [6:0]   len_i;
    logic [1:0]   lanes_i;
    logic [3:0]   sd_drv;
    logic         loop_en;
    logic [3:0]   sd_i;
    logic [3:0]   sd_o, sd_oe_o;
    logic         busy_o, last_o, done_o;
    logic [127:0] rdata_o;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int beat_n = 0;
    int done_ref;
    logic [3:0]   beats [0:255];
    logic [15:0]  obs16;
    logic [127:0] pattern;

    assign sd_i = loop_en ? {sd_drv[3:2], sd_o[0], sd_drv[0]} : sd_drv;

    always #5 clk_i = ~clk_i;

    spi_shift_mlane dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .load_i(load_i),
        .word_sel_i(word_sel_i), .byte_sel_i(byte_sel_i), .wdata_i(wdata_i),
        .len_i(len_i), .lsb_i(lsb_i), .lanes_i(lanes_i),
        .tx_negedge_i(tx_negedge_i), .rx_negedge_i(rx_negedge_i), .go_i(go_i),
        .pos_edge_i(pos_edge_i), .neg_edge_i(neg_edge_i), .sclk_i(sclk_i),
        .tx_en_i(tx_en_i), .rx_en_i(rx_en_i), .sd_i(sd_i), .sd_o(sd_o),
        .sd_oe_o(sd_oe_o), .busy_o(busy_o), .last_o(last_o), .done_o(done_o),
        .rdata_o(rdata_o)
    );

    // Count done pulses, sampled just after each active edge.
    always @(posedge clk_i) begin
        #1;
        if (done_o === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One sclk period: pos strobe (sclk low), sclk high, neg strobe, sclk low.
    // The value on sd_o at each data-carrying pos strobe is recorded.
    task automatic sclk_cycle(input logic [3:0] d);
        @(negedge clk_i);
        sd_drv = d; pos_edge_i = 1'b1; sclk_i = 1'b0;
        if (busy_o === 1'b1 && last_o === 1'b0) begin
            if (beat_n < 256) beats[beat_n] = sd_o;
            beat_n++;
        end
        @(negedge clk_i);
        pos_edge_i = 1'b0; sclk_i = 1'b1;
        @(negedge clk_i);
        neg_edge_i = 1'b1;
        @(negedge clk_i);
        neg_edge_i = 1'b0; sclk_i = 1'b0;
    endtask

    task automatic load_word(input logic [1:0] w, input logic [3:0] s, input logic [31:0] d);
        @(negedge clk_i);
        word_sel_i = w; byte_sel_i = s; wdata_i = d; load_i = 1'b1;
        @(negedge clk_i);
        load_i = 1'b0;
    endtask

    task automatic start();
        beat_n = 0;
        done_ref = done_cnt;
        @(negedge clk_i); go_i = 1'b1;
        @(negedge clk_i); go_i = 1'b0;
    endtask

    task automatic run_xfer(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (busy_o !== 1'b1) break;
            sclk_cycle(4'h0);
        end
        @(negedge clk_i);
        chk("xfer_timeout_busy", busy_o, 1'b0);
    endtask

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; load_i = 1'b0; lsb_i = 1'b0;
        tx_negedge_i = 1'b1; rx_negedge_i = 1'b0; go_i = 1'b0;
        pos_edge_i = 1'b0; neg_edge_i = 1'b0; sclk_i = 1'b0;
        tx_en_i = 1'b1; rx_en_i = 1'b1; word_sel_i = 2'd0; byte_sel_i = 4'h0;
        wdata_i = 32'h0; len_i = 7'd8; lanes_i = 2'd0; sd_drv = 4'h0; loop_en = 1'b1;

        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_sd", sd_o, 4'h0);
        chk("rst_oe", sd_oe_o, 4'h0);
        chk("rst_rdata", rdata_o, 128'h0);
        rst_ni = 1'b1;

        // Single lane, MSB first, len 8, loopback
        load_word(2'd0, 4'hF, 32'h0000_00A5);
        repeat (2) @(negedge clk_i);
        chk("t1_oe", sd_oe_o, 4'b0001);
        chk("t1_predrive", sd_o, 4'b0001);
        start();
        chk("t1_busy", busy_o, 1'b1);
        run_xfer(20);
        chk("t1_beats", beat_n, 8);
        for (int j = 0; j < 8; j++) obs16[7-j] = beats[j][0];
        chk("t1_sd_seq", obs16[7:0], 8'hA5);
        chk("t1_rdata", rdata_o, 128'hA5);
        chk("t1_done", done_cnt - done_ref, 1);
        repeat (3) @(negedge clk_i);
        chk("t1_rdata_hold", rdata_o, 128'hA5);

        // Quad, MSB first, len 16, transmit only
        lanes_i = 2'd2; len_i = 7'd16; rx_en_i = 1'b0; loop_en = 1'b0;
        load_word(2'd0, 4'hF, 32'h0000_1234);
        repeat (2) @(negedge clk_i);
        chk("t2_oe", sd_oe_o, 4'hF);
        start();
        repeat (3) sclk_cycle(4'h0);
        chk("t2_last_early", last_o, 1'b0);
        sclk_cycle(4'h0);
        chk("t2_last", last_o, 1'b1);
        chk("t2_busy_at_last", busy_o, 1'b1);
        run_xfer(10);
        obs16 = {beats[0], beats[1], beats[2], beats[3]};
        chk("t2_sd_seq", obs16, 16'h1234);
        chk("t2_rdata", rdata_o, 128'h0);
        chk("t2_done", done_cnt - done_ref, 1);

        // Dual, LSB first, len 8, receive only
        lanes_i = 2'd1; len_i = 7'd8; lsb_i = 1'b1; tx_en_i = 1'b0; rx_en_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("t3_oe", sd_oe_o, 4'h0);
        start();
        sclk_cycle(4'b0001);
        sclk_cycle(4'b0011);
        sclk_cycle(4'b0000);
        sclk_cycle(4'b0010);
        run_xfer(10);
        chk("t3_rdata", rdata_o, 128'h8D);
        chk("t3_done", done_cnt - done_ref, 1);

        // len 0 (full 128 bits), single lane, LSB first, loopback
        lanes_i = 2'd0; len_i = 7'd0; lsb_i = 1'b1; tx_en_i = 1'b1; loop_en = 1'b1;
        load_word(2'd0, 4'hF, 32'hFFFF_FFFF);
        load_word(2'd0, 4'b0011, 32'h0123_4567);
        load_word(2'd1, 4'hF, 32'h89AB_CDEF);
        load_word(2'd2, 4'hF, 32'hDEAD_BEEF);
        load_word(2'd3, 4'hF, 32'h0F1E_2D3C);
        pattern = 128'h0F1E2D3C_DEADBEEF_89ABCDEF_FFFF4567;
        start();
        run_xfer(200);
        chk("t4_beats", beat_n, 128);
        chk("t4_rdata", rdata_o, pattern);
        chk("t4_done", done_cnt - done_ref, 1);

        // Abort after 3 beats, then a clean 8-bit transfer
        len_i = 7'd8; lsb_i = 1'b0;
        load_word(2'd0, 4'hF, 32'h0000_00A5);
        start();
        repeat (3) sclk_cycle(4'h0);
        @(negedge clk_i); clear_i = 1'b1;
        @(negedge clk_i); clear_i = 1'b0;
        chk("t5_busy_clr", busy_o, 1'b0);
        repeat (3) @(negedge clk_i);
        chk("t5_no_done", done_cnt - done_ref, 0);
        chk("t5_partial", rdata_o, 128'hA0);
        start();
        run_xfer(20);
        chk("t5_beats", beat_n, 8);
        for (int j = 0; j < 8; j++) obs16[7-j] = beats[j][0];
        chk("t5_sd_seq", obs16[7:0], 8'hA5);
        chk("t5_rdata", rdata_o, 128'hA5);
        chk("t5_done", done_cnt - done_ref, 1);

        // Load while busy is ignored
        start();
        sclk_cycle(4'h0);
        load_word(2'd0, 4'hF, 32'hFFFF_FFFF);
        run_xfer(20);
        chk("t6_rdata_noload", rdata_o, 128'hA5);

        // Reset mid-transfer
        start();
        sclk_cycle(4'h0);
        sclk_cycle(4'h0);
        @(negedge clk_i); rst_ni = 1'b0;
        #1;
        chk("t6_rst_busy", busy_o, 1'b0);
        chk("t6_rst_sd", sd_o, 4'h0);
        chk("t6_rst_oe", sd_oe_o, 4'h0);
        chk("t6_rst_done", done_o, 1'b0);
        chk("t6_rst_rdata", rdata_o, 128'h0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
